// File: rtl/uart_rx_if.sv
// Purpose: UART receive port bundle, serial line and baud select in, framed byte and strobes out.
// Latency: none, wires only.
// Backpressure: none; the byte side is strobe-only and the consumer must take it in the strobe cycle.
interface uart_rx_if;
   logic       rx;        // serial line, asynchronous, idle high
   logic [1:0] mode;      // baud select: 00=4800, 01=9600, 10=14.4k, 11=19.2k
   logic [7:0] rx_data;   // last correctly framed byte
   logic       rx_valid;  // one-cycle strobe: rx_data updated
   logic       rx_ferr;   // one-cycle strobe: stop bit low, byte discarded
   logic       rx_busy;   // receiver is inside a frame

   // Receiver side: consumes the line, produces the byte and strobes
   modport master (
      input  rx,
      input  mode,
      output rx_data,
      output rx_valid,
      output rx_ferr,
      output rx_busy
   );

   // Line driver and byte consumer side
   modport slave (
      output rx,
      output mode,
      input  rx_data,
      input  rx_valid,
      input  rx_ferr,
      input  rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// Purpose: 8N1 LSB-first UART receiver with 8x oversampling and 2-of-3 majority vote per bit.
// Latency: rx_valid/rx_ferr about 2 sync cycles + 9*8*DIV + 6*DIV sclk after the start edge.
// Backpressure: none; each byte is strobed for one cycle and held in rx_data until the next good frame.
module uart_rx #(
   parameter int DIV_4800  = 2604,
   parameter int DIV_9600  = 1302,
   parameter int DIV_14_4K = 868,
   parameter int DIV_19_2K = 651
) (
   input  logic      sclk,
   input  logic      sclr_n,
   uart_rx_if.master bus
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   logic        rx_meta;
   logic        rx_s;
   logic        rx_prev;
   logic [1:0]  mode_l;
   logic [11:0] div_cnt;
   logic [11:0] div_last;
   logic [2:0]  sub_cnt;
   logic [2:0]  bit_idx;
   logic [1:0]  smp;       // samples from sub-counts 3 and 4
   logic        bit_val;   // voted value of the current bit
   logic [7:0]  shift;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        ferr_q;
   logic        tick;
   logic        fell;
   logic        vote;

   // Terminal count of the 1/8-bit divider for the baud latched at the start edge
   always_comb begin
      case (mode_l)
         2'b00:   div_last = 12'(DIV_4800 - 1);
         2'b01:   div_last = 12'(DIV_9600 - 1);
         2'b10:   div_last = 12'(DIV_14_4K - 1);
         default: div_last = 12'(DIV_19_2K - 1);
      endcase
   end

   // Divider is parked in IDLE, so ticks only exist inside a frame
   assign tick = (state != IDLE) && (div_cnt == div_last);
   assign fell = rx_prev & ~rx_s;
   // Majority of the two stored samples and the live sample at sub-count 5
   assign vote = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

   // Two-flop synchroniser plus edge history, all reset to the idle-high line level
   always_ff @(posedge sclk or negedge sclr_n) begin
      if (!sclr_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Frame FSM with oversampling counters, vote capture and registered outputs
   always_ff @(posedge sclk or negedge sclr_n) begin
      if (!sclr_n) begin
         state   <= IDLE;
         mode_l  <= 2'b00;
         div_cnt <= '0;
         sub_cnt <= '0;
         bit_idx <= '0;
         smp     <= '0;
         bit_val <= 1'b0;
         shift   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;

         if (state == IDLE || tick) div_cnt <= '0;
         else                       div_cnt <= div_cnt + 12'd1;

         if (tick) begin
            sub_cnt <= sub_cnt + 3'd1;   // wraps 7 -> 0 at each bit boundary
            if (sub_cnt == 3'd3) smp[0]  <= rx_s;
            if (sub_cnt == 3'd4) smp[1]  <= rx_s;
            if (sub_cnt == 3'd5) bit_val <= vote;
         end

         case (state)
            IDLE: begin
               if (fell) begin
                  mode_l  <= bus.mode;
                  sub_cnt <= '0;
                  state   <= START;
               end
            end
            START: begin
               // A start bit that is high at mid-bit was a glitch
               if (tick && sub_cnt == 3'd5 && vote) begin
                  state <= IDLE;
               end else if (tick && sub_cnt == 3'd7) begin
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (tick && sub_cnt == 3'd7) begin
                  shift   <= {bit_val, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               // Decide mid stop bit so a back-to-back start edge is not missed
               if (tick && sub_cnt == 3'd5) begin
                  if (vote) begin
                     data_q  <= shift;
                     valid_q <= 1'b1;
                  end else begin
                     ferr_q  <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rx_data  = data_q;
   assign bus.rx_valid = valid_q;
   assign bus.rx_ferr  = ferr_q;
   assign bus.rx_busy  = (state != IDLE);

endmodule
